// File: rtl/subtractor_pipe_pkg.sv
// subtractor_pipe_pkg: shared constants and types for the subtractor_pipe slice.
//   WIDTH_DEF / LATENCY_DEF : default operand width and latency
//   LATENCY_MAX             : largest supported latency (legal range 1..LATENCY_MAX)
//   result_t                : packed {bo, diff} at the default width
//   sample_t                : packed {a, b, bi} at the default width
package subtractor_pipe_pkg;

   localparam int unsigned WIDTH_DEF   = 4;
   localparam int unsigned LATENCY_DEF = 12;
   localparam int unsigned LATENCY_MAX = 32;

   typedef struct packed {
      logic                 bo;
      logic [WIDTH_DEF-1:0] diff;
   } result_t;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] a;
      logic [WIDTH_DEF-1:0] b;
      logic                 bi;
   } sample_t;

endpackage

// File: rtl/subtractor_pipe_if.sv
// subtractor_pipe_if: operand/result bundle of subtractor_pipe.
//   flush, in_valid, a, b, bi : driven by the master (operand source)
//   out_valid, diff, bo       : driven by the slave (subtractor_pipe)
interface subtractor_pipe_if
   import subtractor_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bi;
   logic             out_valid;
   logic [WIDTH-1:0] diff;
   logic             bo;

   modport master (
      output flush, in_valid, a, b, bi,
      input  out_valid, diff, bo
   );

   modport slave (
      input  flush, in_valid, a, b, bi,
      output out_valid, diff, bo
   );
endinterface

// File: rtl/subtractor_pipe_delay_line.sv
// delay_line: valid+payload shift register of DEPTH stages.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_flush           : synchronous clear of every valid bit
//   i_valid, i_data   : stage-0 input
//   o_valid, o_data   : last stage; o_data only loads alongside a valid, so it
//                       holds the last emitted payload between pulses
module delay_line #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);
   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      end else begin
         r_valid[0] <= i_valid & ~i_flush;
         if (i_valid && !i_flush) r_data[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1] & ~i_flush;
            // Payload moves only with its valid, so a flushed stage never
            // disturbs the held output value.
            if (r_valid[i-1] && !i_flush) r_data[i] <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];
endmodule

// File: rtl/subtractor_pipe.sv
// subtractor_pipe: WIDTH-bit subtract-with-borrow, result after LATENCY cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : subtractor_pipe_if slave (flush, in_valid, a, b, bi ->
//                out_valid, diff, bo)
// Build option SUBTRACTOR_PIPE_INERTIAL_EN: replace the transport delay line
// with inertial filtering (only tuples stable for LATENCY cycles emerge, once).
// LATENCY must lie in 1..LATENCY_MAX.
module subtractor_pipe
   import subtractor_pipe_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned LATENCY = LATENCY_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   subtractor_pipe_if.slave  bus
);
   // {bo, diff}: a borrow out of the WIDTH+1-bit subtraction lands in the MSB.
   logic [WIDTH:0] w_res;
   assign w_res = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.bi};

`ifdef SUBTRACTOR_PIPE_INERTIAL_EN
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [2*WIDTH:0] w_sample;
   logic [2*WIDTH:0] r_prev;
   logic             r_prev_valid;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_armed;
   logic             w_load;
   logic             w_fire;
   logic             r_out_valid;
   logic [WIDTH:0]   r_res;

   always_comb begin
      w_sample  = {bus.a, bus.b, bus.bi};
      // A new tuple or a rising in_valid restarts the stability window.
      w_load    = bus.in_valid & (~r_prev_valid | (w_sample != r_prev));
      w_cnt_nxt = w_load ? CNT_W'(LATENCY - 1) : r_cnt - 1'b1;
      // Firing on the edge the count reaches zero puts the pulse exactly
      // LATENCY cycles after the last change; LATENCY=1 fires on the load edge.
      w_fire    = bus.in_valid & ~bus.flush & (w_load | r_armed) & (w_cnt_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
         r_cnt        <= '0;
         r_armed      <= 1'b0;
         r_out_valid  <= 1'b0;
         r_res        <= '0;
      end else begin
         r_prev_valid <= bus.in_valid;
         if (bus.in_valid) r_prev <= w_sample;
         if (w_load || r_armed) r_cnt <= w_cnt_nxt;
         // Disarm after firing so a tuple held indefinitely emits only once.
         r_armed      <= bus.in_valid & ~bus.flush & (w_load | r_armed) & ~w_fire;
         r_out_valid  <= w_fire;
         if (w_fire) r_res <= w_res;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.bo        = r_res[WIDTH];
   assign bus.diff      = r_res[WIDTH-1:0];
`else
   logic           w_dl_valid;
   logic [WIDTH:0] w_dl_data;

   delay_line #(
      .WIDTH (WIDTH + 1),
      .DEPTH (LATENCY)
   ) u_delay_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (bus.flush),
      .i_valid (bus.in_valid),
      .i_data  (w_res),
      .o_valid (w_dl_valid),
      .o_data  (w_dl_data)
   );

   assign bus.out_valid = w_dl_valid;
   assign bus.bo        = w_dl_data[WIDTH];
   assign bus.diff      = w_dl_data[WIDTH-1:0];
`endif
endmodule
